ysyx_25040109_idu_pipe: RTL and testbench
=========================================

# ysyx_25040109_idu_pipe

Registered, handshaked instruction-decode stage between the IFU and EXU of the ysyx_25040109 core. It is the pipelined successor of the combinational decoder and adds the following:
- valid/ready flow control on both sides;
- a 2-entry skid buffer, so the upstream ready is registered;
- flush support;
- parametrised M / Zicsr enables;
- extra decoded outputs: rs1/rs2 indices and use flags, rd-zero write suppression, and a CSR zimm immediate.

Each accepted instruction produces exactly one decoded bundle, in order.

## Interface
Parameters:
- XLEN, 32: width of pc and imm (only 32 is supported).
- EN_M, 1: 1 = RV32M opcodes are legal; 0 = RV32M opcodes are flagged illegal.
- EN_ZICSR, 1: 1 = CSR instructions are legal; 0 = only ECALL, EBREAK and MRET are legal in the SYSTEM opcode.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: synchronous reset, active-high.
- flush, input, 1: discards all buffered and in-flight-accepted instructions.
- in_valid, input, 1: IFU offers an instruction.
- in_ready, output, 1: stage can accept an instruction. Registered.
- in_inst, input, 32: instruction word.
- in_pc, input, XLEN: pc of the instruction.
- out_valid, output, 1: decoded bundle is available.
- out_ready, input, 1: EXU consumes the bundle.
- out_pc, output, XLEN: pc passed through.
- out_inst, output, 32: raw instruction passed through.
- out_rd, output, 5: inst[11:7].
- out_rs1, output, 5: inst[19:15].
- out_rs2, output, 5: inst[24:20].
- out_rs1_use, output, 1: instruction reads rs1.
- out_rs2_use, output, 1: instruction reads rs2.
- out_imm, output, XLEN: sign-extended immediate.
- out_wen, output, 1: instruction writes rd.
- out_funct3, output, 3: inst[14:12].
- out_funct7, output, 7: inst[31:25].
- out_csr_addr, output, 12: inst[31:20].
- out_illegal, output, 1: instruction is not a legal encoding under the current parameters.

## Operation
- Decode is combinational on in_inst. The result is captured together with pc and inst into a storage entry.
- Immediate selection by opcode:
  - LUI / AUIPC: U-type.
  - OP-IMM, LOAD, JALR: I-type.
  - STORE: S-type.
  - JAL: J-type.
  - BRANCH: B-type.
  - SYSTEM with funct3[2]=1: zimm = zero-extended inst[19:15].
  - Anything else: 0.
- out_wen is 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and SYSTEM with funct3≠0. It is forced to 0 when rd=0 or when the instruction is illegal.
- out_rs1_use = 1 for JALR, LOAD, STORE, BRANCH, OP-IMM, OP, and SYSTEM with funct3 ∈ {001,010,011}.
- out_rs2_use = 1 for STORE, BRANCH, OP.
- out_illegal = 1 in any of these cases:
  - inst[1:0] ≠ 11;
  - unknown opcode;
  - JALR with funct3 ≠ 000;
  - LOAD with funct3 ∈ {011,110,111};
  - STORE with funct3 ≥ 011;
  - BRANCH with funct3 ∈ {010,011};
  - OP-IMM shifts with a bad funct7 (SLLI requires funct7 0000000; SRLI/SRAI require 0000000 or 0100000);
  - OP with any funct7 other than 0000000, 0100000 (ADD/SUB/SRL/SRA only for 0100000), or 0000001;
  - an OP with funct7 0000001 (all 8 M funct3 values legal) while EN_M=0;
  - SYSTEM with funct3=000 and funct12 ∉ {000, 001, 302};
  - SYSTEM with funct3=100;
  - SYSTEM CSR funct3 while EN_ZICSR=0.
- Storage is two entries, main and skid, each with a valid bit.
  - The out_* signals are driven from main.
  - in_ready = !skid_valid, registered.
- Per-cycle behaviour, with acc = in_valid & in_ready and deq = out_valid & out_ready:
  - Main empty, acc: new instruction → main.
  - Main full, deq, skid empty, acc: new instruction → main.
  - Main full, deq, skid full: skid → main. No accept is possible because in_ready = 0.
  - Main full, !deq, acc: new instruction → skid.
  - Main full, deq, no acc, skid empty: main becomes empty.
- Illegal instructions flow through normally with out_illegal=1. The stage never drops or stalls on them.

## Timing
- Latency: accept in cycle N → out_valid in cycle N+1. Sustained throughput is 1 instruction per cycle while out_ready=1.
- While out_valid=1 && out_ready=0, all out_* signals hold stable.
- Reset (rst=1 at a clk edge):
  - main and skid valid bits cleared;
  - out_valid = 0;
  - in_ready = 1;
  - all out_* data = 0.
- Reset mid-transfer discards everything buffered.
- flush at a clk edge:
  - clears both valid bits, so out_valid=0 and in_ready=1 the next cycle;
  - an instruction accepted in the same cycle is discarded;
  - flush takes priority over acc and deq.
- rst has priority over flush.
- out_valid and in_ready are never combinational from in_valid or out_ready.

## Test plan
- **Stream, no backpressure.** After reset, in_valid=1 with addi x1,x0,5 (0x00500093) then lui x2,0x12345 (0x12345137), out_ready=1.
  - Cycle 1: out_imm=5, out_wen=1, out_rs1_use=1.
  - Cycle 2: out_imm=0x12345000, out_rd=2.
  - No bubbles.
- **Backpressure.** out_ready=0 while 3 instructions are offered.
  - 2 are accepted; in_ready=0 after the second.
  - The first bundle holds stable.
  - Releasing out_ready delivers all 3 in order; in_ready returns to 1 one cycle after the skid drains.
- **Illegal and wen rules.**
  - mul with EN_M=0 → out_illegal=1, out_wen=0.
  - Same instruction with EN_M=1 → out_illegal=0.
  - add x0,x1,x2 → out_wen=0, out_illegal=0.
  - 0x00000000 → out_illegal=1.
- **Immediates.**
  - beq offset −4 (0xFE000EE3) → out_imm=0xFFFFFFFC.
  - csrrwi x1,mstatus,31 (0x300FD0F3) → out_imm=31, out_csr_addr=0x300.
  - sw offset −1 → out_imm=0xFFFFFFFF.
- **Flush.** Fill both entries, then assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and no instruction from the flush cycle is ever output.
- **Reset mid-stream.** rst=1 for one cycle while out_valid=1 and out_ready=0 → out_valid=0, in_ready=1, all out_*=0.

Source files
------------

// File: rtl/ysyx_25040109_idu_pipe.sv
// ysyx_25040109 instruction-decode stage: combinational RV32I/M/Zicsr decode
// captured into a two-entry (main + skid) buffer with valid/ready on both sides.
module ysyx_25040109_idu_pipe #(
  parameter int XLEN     = 32,
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rs1_use,
  output logic            out_rs2_use,
  output logic [XLEN-1:0] out_imm,
  output logic            out_wen,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [11:0]     out_csr_addr,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic            wen;
    logic            rs1_use;
    logic            rs2_use;
    logic            illegal;
  } entry_t;

  entry_t dec, main_q, skid_q;
  logic   main_v, skid_v;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] f12;
  logic [31:0] i;

  assign i   = in_inst;
  assign opc = i[6:0];
  assign f3  = i[14:12];
  assign f7  = i[31:25];
  assign f12 = i[31:20];

  logic is_lui, is_auipc, is_jal, is_jalr, is_load;
  logic is_store, is_branch, is_opimm, is_op, is_sys;

  assign is_lui    = opc == 7'b0110111;
  assign is_auipc  = opc == 7'b0010111;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111;
  assign is_load   = opc == 7'b0000011;
  assign is_store  = opc == 7'b0100011;
  assign is_branch = opc == 7'b1100011;
  assign is_opimm  = opc == 7'b0010011;
  assign is_op     = opc == 7'b0110011;
  assign is_sys    = opc == 7'b1110011;

  logic [31:0] imm;
  logic        wen, r1, r2, ill;

  always_comb begin
    imm = '0;
    wen = 1'b0;
    r1  = 1'b0;
    r2  = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc: begin
        imm = {i[31:12], 12'b0};
        wen = 1'b1;
      end
      is_jal: begin
        imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        wen = 1'b1;
      end
      is_jalr: begin
        imm = {{20{i[31]}}, i[31:20]};
        wen = 1'b1;
        r1  = 1'b1;
        ill = f3 != 3'd0;
      end
      is_load: begin
        imm = {{20{i[31]}}, i[31:20]};
        wen = 1'b1;
        r1  = 1'b1;
        ill = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      is_store: begin
        imm = {{20{i[31]}}, i[31:25], i[11:7]};
        r1  = 1'b1;
        r2  = 1'b1;
        ill = f3 >= 3'd3;
      end
      is_branch: begin
        imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        r1  = 1'b1;
        r2  = 1'b1;
        ill = f3 == 3'd2 || f3 == 3'd3;
      end
      is_opimm: begin
        imm = {{20{i[31]}}, i[31:20]};
        wen = 1'b1;
        r1  = 1'b1;
        ill = (f3 == 3'd1 && f7 != 7'h00) ||
              (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      is_op: begin
        wen = 1'b1;
        r1  = 1'b1;
        r2  = 1'b1;
        unique case (f7)
          7'h00:   ill = 1'b0;
          7'h20:   ill = !(f3 == 3'd0 || f3 == 3'd5);
          7'h01:   ill = !EN_M;
          default: ill = 1'b1;
        endcase
      end
      is_sys: begin
        if (f3[2]) imm = {27'b0, i[19:15]};
        wen = f3 != 3'd0;
        r1  = f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3;
        if (f3 == 3'd0)
          ill = !(f12 == 12'h000 || f12 == 12'h001 || f12 == 12'h302);
        else if (f3 == 3'd4)
          ill = 1'b1;
        else
          ill = !EN_ZICSR;
      end
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.inst    = in_inst;
    dec.imm     = imm;
    dec.rs1_use = r1;
    dec.rs2_use = r2;
    dec.illegal = ill;
    dec.wen     = wen && !ill && i[11:7] != 5'd0;
  end

  logic acc, deq;
  assign acc = in_valid && !skid_v;
  assign deq = main_v && out_ready;

  // skid only fills while main is held, so main empty implies skid empty
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      if (acc) begin
        main_q <= dec;
        main_v <= 1'b1;
      end
    end else if (deq) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (acc) begin
        main_q <= dec;
      end else begin
        main_v <= 1'b0;
      end
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign in_ready     = !skid_v;
  assign out_valid    = main_v;
  assign out_pc       = main_q.pc;
  assign out_inst     = main_q.inst;
  assign out_rd       = main_q.inst[11:7];
  assign out_rs1      = main_q.inst[19:15];
  assign out_rs2      = main_q.inst[24:20];
  assign out_funct3   = main_q.inst[14:12];
  assign out_funct7   = main_q.inst[31:25];
  assign out_csr_addr = main_q.inst[31:20];
  assign out_rs1_use  = main_q.rs1_use;
  assign out_rs2_use  = main_q.rs2_use;
  assign out_imm      = main_q.imm;
  assign out_wen      = main_q.wen;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_ysyx_25040109_idu_pipe.sv
// Bench for ysyx_25040109_idu_pipe: directed stream with a scoreboard,
// plus a second instance with M and Zicsr disabled fed the same stimulus.
module tb_ysyx_25040109_idu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, rs1_use, rs2_use, wen, illegal;
  logic [31:0] out_pc, out_inst, out_imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] csr;

  logic        in_ready2, out_valid2, rs1_use2, rs2_use2, wen2, illegal2;
  logic [31:0] out_pc2, out_inst2, out_imm2;
  logic [4:0]  rd2, rs1b, rs2b;
  logic [2:0]  f3b;
  logic [6:0]  f7b;
  logic [11:0] csr2;

  always #5 clk = ~clk;

  ysyx_25040109_idu_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .out_rd(rd), .out_rs1(rs1), .out_rs2(rs2),
    .out_rs1_use(rs1_use), .out_rs2_use(rs2_use),
    .out_imm(out_imm), .out_wen(wen),
    .out_funct3(f3), .out_funct7(f7),
    .out_csr_addr(csr), .out_illegal(illegal)
  );

  ysyx_25040109_idu_pipe #(.EN_M(1'b0), .EN_ZICSR(1'b0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_inst(out_inst2),
    .out_rd(rd2), .out_rs1(rs1b), .out_rs2(rs2b),
    .out_rs1_use(rs1_use2), .out_rs2_use(rs2_use2),
    .out_imm(out_imm2), .out_wen(wen2),
    .out_funct3(f3b), .out_funct7(f7b),
    .out_csr_addr(csr2), .out_illegal(illegal2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        wen, ill, r1u, r2u, wen2, ill2;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] next_pc = 32'h8000_0000;
  logic [31:0] held;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] imm,
                      input logic w, input logic il, input logic a,
                      input logic b, input logic w2, input logic il2);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = next_pc;
    cur      = '{next_pc, inst, imm, w, il, a, b, w2, il2};
    next_pc  = next_pc + 32'd4;
  endtask

  // scoreboard: pop on delivery, push on acceptance, drop on flush/reset
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_inst, 32'hxxxxxxxx);
        end else begin
          e = q.pop_front();
          chk("pc", out_pc, e.pc);
          chk("inst", out_inst, e.inst);
          chk("imm", out_imm, e.imm);
          chk("wen", {31'b0, wen}, {31'b0, e.wen});
          chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
          chk("rs1_use", {31'b0, rs1_use}, {31'b0, e.r1u});
          chk("rs2_use", {31'b0, rs2_use}, {31'b0, e.r2u});
          chk("rd", {27'b0, rd}, {27'b0, e.inst[11:7]});
          chk("csr_addr", {20'b0, csr}, {20'b0, e.inst[31:20]});
          chk("wen_nomz", {31'b0, wen2}, {31'b0, e.wen2});
          chk("ill_nomz", {31'b0, illegal2}, {31'b0, e.ill2});
        end
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
  end

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LUI   = 32'h12345137;
  localparam logic [31:0] MUL   = 32'h022081B3;
  localparam logic [31:0] ADDX0 = 32'h00208033;
  localparam logic [31:0] ZERO  = 32'h00000000;
  localparam logic [31:0] BEQ   = 32'hFE000EE3;
  localparam logic [31:0] CSRWI = 32'h300FD0F3;
  localparam logic [31:0] SW    = 32'hFE002FA3;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    cur = '{default: '0};
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_inst", out_inst, 32'd0);

    // stream without backpressure
    out_ready = 1'b1;
    send(ADDI, 32'd5, 1, 0, 1, 0, 1, 0);
    step();
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    send(LUI, 32'h12345000, 1, 0, 0, 0, 1, 0);
    step();
    chk("nobubble", {31'b0, out_valid}, 32'd1);
    chk("lui_rd", {27'b0, rd}, 32'd2);
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // backpressure: two accepted, third waits
    out_ready = 1'b0;
    send(MUL, 32'd0, 1, 0, 1, 1, 0, 1);
    step();
    send(ADDX0, 32'd0, 0, 0, 1, 1, 0, 0);
    step();
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    held = out_inst;
    chk("bp_head", held, MUL);
    send(ZERO, 32'd0, 0, 1, 0, 0, 0, 1);
    step(); step();
    chk("bp_hold_inst", out_inst, held);
    chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // immediates
    send(BEQ, 32'hFFFFFFFC, 0, 0, 1, 1, 0, 0);
    step();
    send(CSRWI, 32'd31, 1, 0, 0, 0, 0, 1);
    step();
    send(SW, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0);
    step();
    in_valid = 1'b0;
    step(); step();

    // flush with both entries full and a new offer
    out_ready = 1'b0;
    send(ADDI, 32'd5, 1, 0, 1, 0, 1, 0);
    step();
    send(LUI, 32'h12345000, 1, 0, 0, 0, 1, 0);
    step();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    send(ADDX0, 32'd0, 0, 0, 1, 1, 0, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step(); step();
    chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);

    // reset while a bundle is held
    out_ready = 1'b0;
    send(LUI, 32'h12345000, 1, 0, 0, 0, 1, 0);
    step();
    in_valid = 1'b0;
    chk("mr_valid_pre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mr_imm", out_imm, 32'd0);
    chk("mr_pc", out_pc, 32'd0);
    chk("mr_rd", {27'b0, rd}, 32'd0);
    chk("mr_wen", {31'b0, wen}, 32'd0);
    chk("mr_valid2", {31'b0, out_valid2}, 32'd0);
    step(); step();

    chk("sb_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
